// File: rtl/aes_round_sequencer_if.sv
// Bundle between the AES round sequencer and its surroundings: plaintext stream,
// round-key store lookup, shared round datapath and ciphertext stream.
interface aes_round_sequencer_if;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned IDX_W  = 4;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  rk_idx;
    logic [DATA_W-1:0] rk;
    logic [DATA_W-1:0] rnd_state;
    logic [DATA_W-1:0] rnd_key;
    logic              rnd_final;
    logic [DATA_W-1:0] rnd_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    // master = sequencer, slave = producer/consumer/key store/datapath side
    modport master (
        input  in_valid, in_data, rk, rnd_result, out_ready,
        output in_ready, rk_idx, rnd_state, rnd_key, rnd_final, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_data, rk, rnd_result, out_ready,
        input  in_ready, rk_idx, rnd_state, rnd_key, rnd_final, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: initial AddRoundKey on accept, then
// NUM_ROUNDS-1 middle rounds and one final round through a shared round datapath.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned ROUND_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_round_sequencer_if.master bus
);
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PH_W   = $clog2(ROUND_LAT + 2);

    localparam logic [CNT_W-1:0] LAST_MID  = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(NUM_ROUNDS);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(ROUND_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   ph_q, ph_d;

    logic              in_ready_c;
    logic              out_valid_c;
    logic              rnd_final_c;
    logic              busy_c;
    logic [CNT_W-1:0]  rk_idx_c;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
        end
    end

    // Next-state and decoded controls; round inputs stay frozen until the capture phase
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        rnd_final_c = 1'b0;
        busy_c      = 1'b0;
        rk_idx_c    = '0;

        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    st_d    = bus.in_data ^ bus.rk;
                    cnt_d   = CNT_W'(1);
                    ph_d    = '0;
                    state_d = (NUM_ROUNDS > 1) ? ROUND : FINAL;
                end
            end
            ROUND: begin
                busy_c   = 1'b1;
                rk_idx_c = cnt_q;
                if (ph_q == PH_LAST) begin
                    st_d = bus.rnd_result;
                    ph_d = '0;
                    // Counter saturates at the last middle round instead of stepping past it
                    if (cnt_q == LAST_MID) begin
                        state_d = FINAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            FINAL: begin
                busy_c      = 1'b1;
                rnd_final_c = 1'b1;
                rk_idx_c    = FINAL_IDX;
                if (ph_q == PH_LAST) begin
                    st_d    = bus.rnd_result;
                    ph_d    = '0;
                    state_d = DONE;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output is held at zero while reset is asserted
    assign bus.in_ready  = in_ready_c  & ~rst;
    assign bus.out_valid = out_valid_c & ~rst;
    assign bus.rnd_final = rnd_final_c & ~rst;
    assign bus.busy      = busy_c      & ~rst;
    assign bus.rk_idx    = rst ? '0 : rk_idx_c;
    assign bus.rnd_state = rst ? '0 : st_q;
    assign bus.out_data  = rst ? '0 : st_q;
    assign bus.rnd_key   = rst ? '0 : bus.rk;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: behavioural AES round units and key store around the
// DUT, a full-cipher reference model, and a cycle monitor for timing and handshake rules.
module tb_aes_round_sequencer;
    localparam int unsigned NR  = 10;
    localparam int unsigned LAT = 2;
    localparam int          BLK = NR * (LAT + 1);

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_round_sequencer_if bus ();

    aes_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES reference pieces ----------------
    logic [7:0]   sbox_tab [256];
    logic [127:0] rkeys    [16];
    logic         use_stub = 1'b0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox_tab[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++) b[rw + 4*c] = a[rw + 4*((c + rw) % 4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i] ^ k[127-8*i -: 8];
        return r;
    endfunction

    task automatic set_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                  ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rkeys[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Whole-block expectation: full cipher, or NR increments when the stub datapath is in use
    function automatic logic [127:0] expect_ct(input logic [127:0] pt);
        logic [127:0] s;
        if (use_stub) return pt + 128'(NR);
        s = pt ^ rkeys[0];
        for (int r = 1; r < NR; r++) s = aes_round(s, rkeys[r], 1'b0);
        return aes_round(s, rkeys[NR], 1'b1);
    endfunction

    // ---------------- environment: key store and two-stage round datapath ----------------
    logic [127:0] p1, p2;
    assign bus.rk         = use_stub ? 128'h0 : rkeys[bus.rk_idx];
    assign bus.rnd_result = p2;

    always_ff @(posedge clk) begin
        p1 <= use_stub ? bus.rnd_state + 128'd1 : aes_round(bus.rnd_state, bus.rnd_key, bus.rnd_final);
        p2 <= p1;
    end

    int rdy_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic [127:0] exp_q [$];
    logic [127:0] last_out = '0;
    logic [127:0] st_hold  = '0;
    int  cyc = 0, acc_cyc = 0, last_acc = 0, terr = 0, n_out = 0;
    bit  pending = 0, prev_ov = 0, hs_prev = 0, rst_seen = 0;

    initial begin
        int k, j;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_outputs", 128'({bus.in_ready, bus.out_valid, bus.busy, bus.rnd_final, bus.rk_idx})
                      | bus.rnd_state | bus.rnd_key | bus.out_data, 128'h0);
                exp_q.delete();
                pending  = 0;
                hs_prev  = 0;
                rst_seen = 1;
            end else begin
                if (rst_seen) check("rdy_after_rst", 128'(bus.in_ready), 128'(1));
                if (hs_prev)  check("rdy_after_hs", 128'(bus.in_ready), 128'(1));
                rst_seen = 0;
                hs_prev  = 0;
                if (bus.busy) check("no_rdy_busy", 128'(bus.in_ready), 128'(0));
                if (pending && !bus.out_valid) begin
                    k = cyc - acc_cyc;
                    if (k >= 1 && k <= BLK) begin
                        j = (k - 1) / (LAT + 1) + 1;
                        if (bus.rk_idx != 4'(j) || bus.rnd_final != (j == NR) || !bus.busy
                            || bus.rnd_key != bus.rk) terr++;
                        if ((k - 1) % (LAT + 1) == 0) st_hold = bus.rnd_state;
                        else if (bus.rnd_state != st_hold) terr++;
                    end
                end
                if (bus.out_valid && !prev_ov) begin
                    check("ov_pending", 128'(pending), 128'(1));
                    check("latency", 128'(cyc - acc_cyc), 128'(BLK + 1));
                    check("round_trace", 128'(terr), 128'(0));
                    check("done_idx", 128'({bus.rk_idx, bus.rnd_final}), 128'(0));
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("rdy_in_done", 128'(bus.in_ready), 128'(0));
                    if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
                    else check("unexpected_out", 128'(1), 128'(0));
                    last_out = bus.out_data;
                    pending  = 0;
                    hs_prev  = 1;
                    n_out++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(expect_ct(bus.in_data));
                    acc_cyc  = cyc;
                    last_acc = cyc;
                    pending  = 1;
                    terr     = 0;
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    // Offer pt and return in the cycle after acceptance; in_valid is left high
    task automatic send(input logic [127:0] pt);
        bit ok;
        ok = 0;
        drive_slot();
        bus.in_valid = 1'b1;
        bus.in_data  = pt;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 128'(0), 128'(1));
        drive_slot();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 128'(exp_q.size()), 128'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] cap;
        int errs, prev, n_before;
        bit seen;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        build_sbox();
        set_key(FIPS_KEY);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Known-answer block through real round units
        send(FIPS_PT);
        bus.in_valid = 1'b0;
        wait_drain();
        check("fips_ct", last_out, FIPS_CT);

        // Increment stub: ten rounds add ten
        drive_slot();
        use_stub = 1'b1;
        send(128'h0);
        bus.in_valid = 1'b0;
        wait_drain();
        check("stub_ct", last_out, 128'd10);
        drive_slot();
        use_stub = 1'b0;

        // Backpressure on the output
        rdy_mode = 2;
        send(FIPS_PT);
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
        end
        check("bp_valid_seen", 128'(seen), 128'(1));
        cap  = bus.out_data;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_data != cap || bus.in_ready || !bus.out_valid) errs++;
        end
        check("bp_hold", 128'(errs), 128'(0));
        check("bp_data", cap, FIPS_CT);
        rdy_mode = 0;
        wait_drain();

        // Offers during ROUND carry other data and must be ignored
        send(FIPS_PT);
        bus.in_valid = 1'b0;
        repeat (4) drive_slot();
        bus.in_valid = 1'b1;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        repeat (2) drive_slot();
        bus.in_valid = 1'b0;
        wait_drain();
        check("ignore_busy_ct", last_out, FIPS_CT);

        // Reset twelve cycles into a block discards it
        n_before = n_out;
        send(FIPS_PT);
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        drive_slot();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_out", 128'(n_out), 128'(n_before));
        send(FIPS_PT);
        bus.in_valid = 1'b0;
        wait_drain();
        check("post_rst_ct", last_out, FIPS_CT);

        // Back-to-back with in_valid and out_ready held high
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom, $urandom, $urandom});
            if (i > 0) check("b2b_spacing", 128'(last_acc - prev), 128'(BLK + 2));
            prev = last_acc;
        end
        bus.in_valid = 1'b0;
        wait_drain();

        // Random keys, plaintexts, gaps and output stalls
        rdy_mode = 1;
        for (int b = 0; b < 20; b++) begin
            drive_slot();
            set_key({$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 3)) drive_slot();
            send({$urandom, $urandom, $urandom, $urandom});
            bus.in_valid = 1'b0;
            wait_drain();
        end
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
